// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants and the fetch FSM state type.
//   NOP_INST         - canonical bubble instruction (addi x0, x0, 0)
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   fetch_state_t    - fetch FSM states
package fetch_stage_pkg;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding memory read and an IF/ID register.
//   i_decode_clk / i_decode_reset - clock, asynchronous active-high reset
//   i_fetch_stall                 - freeze IF/ID (response parked in a hold buffer)
//   i_fetch_flush / i_fetch_redirect_pc - redirect PC, kill in-flight fetch
//   o_imem_req / o_imem_addr      - one-cycle read request at pc
//   i_imem_rvalid / i_imem_rdata  - read response
//   o_fetch_pc / o_fetch_inst / o_fetch_valid - IF/ID register to decode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_decode_clk,
    input  logic        i_decode_reset,
    input  logic        i_fetch_stall,
    input  logic        i_fetch_flush,
    input  logic [31:0] i_fetch_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_inst,
    output logic        o_fetch_valid
);
    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d, hold_pc, hold_pc_d, hold_inst, hold_inst_d;
    logic [31:0]  id_pc, id_pc_d, id_inst, id_inst_d;
    logic         id_valid, id_valid_d, deliver;

    // An instruction reaches IF/ID this edge either straight from memory or from the hold buffer.
    assign deliver = !i_fetch_stall && ((state == S_WAIT && i_imem_rvalid) || state == S_HOLD);

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        hold_pc_d   = hold_pc;
        hold_inst_d = hold_inst;
        id_pc_d     = id_pc;
        id_inst_d   = id_inst;
        id_valid_d  = id_valid;
        if (i_fetch_flush) begin
            pc_d       = i_fetch_redirect_pc;
            id_pc_d    = 32'h0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            // A response still owed by memory must be swallowed in S_DROP; otherwise refetch at once.
            state_d    = (state == S_REQ || (state != S_HOLD && !i_imem_rvalid)) ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_REQ:  state_d = S_WAIT;
                S_WAIT: if (i_imem_rvalid) begin
                    state_d = i_fetch_stall ? S_HOLD : S_REQ;
                    if (i_fetch_stall) begin
                        hold_pc_d   = pc;
                        hold_inst_d = i_imem_rdata;
                    end
                end
                S_HOLD: if (!i_fetch_stall) state_d = S_REQ;
                S_DROP: if (i_imem_rvalid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
            if (!i_fetch_stall) begin
                id_valid_d = deliver;
                id_pc_d    = state == S_HOLD ? hold_pc : deliver ? pc : id_pc;
                id_inst_d  = state == S_HOLD ? hold_inst : deliver ? i_imem_rdata : NOP_INST;
                if (deliver) pc_d = pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_decode_clk or posedge i_decode_reset) begin
        if (i_decode_reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            hold_pc   <= 32'h0;
            hold_inst <= 32'h0;
            id_pc     <= 32'h0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            hold_pc   <= hold_pc_d;
            hold_inst <= hold_inst_d;
            id_pc     <= id_pc_d;
            id_inst   <= id_inst_d;
            id_valid  <= id_valid_d;
        end
    end

    // Gated by reset so an abandoned request is never presented while reset is held.
    assign o_imem_req    = state == S_REQ && !i_decode_reset;
    assign o_imem_addr   = pc;
    assign o_fetch_pc    = id_pc;
    assign o_fetch_inst  = id_inst;
    assign o_fetch_valid = id_valid;
endmodule
